// File: rtl/fpu_issue_pkg.sv
// Shared encodings and decode helpers for the FP issue controller.
// Everything that maps an OP-FP func5 onto a class, latency or register file lives here.
package fpu_issue_pkg;

  localparam logic [6:0] OP_FP = 7'b1010011;

  localparam logic [4:0] FADD     = 5'b00000;
  localparam logic [4:0] FSUB     = 5'b00001;
  localparam logic [4:0] FMUL     = 5'b00010;
  localparam logic [4:0] FDIV     = 5'b00011;
  localparam logic [4:0] FSQRT    = 5'b01011;
  localparam logic [4:0] FCVT_W_S = 5'b11000;
  localparam logic [4:0] FCVT_S_W = 5'b11010;
  localparam logic [4:0] FMV_X_W  = 5'b11100;
  localparam logic [4:0] FMV_W_X  = 5'b11110;
  localparam logic [4:0] FCLASS   = 5'b11100;
  localparam logic [4:0] FCMP     = 5'b10100;

  typedef enum logic [1:0] {
    CLS_ADD  = 2'b00,
    CLS_MUL  = 2'b01,
    CLS_DIV  = 2'b10,
    CLS_MISC = 2'b11
  } fp_class_e;

  // Unlisted encodings fall into MISC so the outputs never carry X.
  function automatic fp_class_e class_of(input logic [4:0] func5);
    case (func5)
      FADD, FSUB:  return CLS_ADD;
      FMUL:        return CLS_MUL;
      FDIV, FSQRT: return CLS_DIV;
      default:     return CLS_MISC;
    endcase
  endfunction

  function automatic int lat_of(input fp_class_e cls, input int lat_add, input int lat_mul,
                                input int lat_div, input int lat_misc);
    case (cls)
      CLS_ADD: return lat_add;
      CLS_MUL: return lat_mul;
      CLS_DIV: return lat_div;
      default: return lat_misc;
    endcase
  endfunction

  function automatic logic dest_is_int(input logic [4:0] func5);
    return func5 inside {FMV_X_W, FCLASS, FCVT_W_S, FCMP};
  endfunction

  function automatic logic rs1_is_int(input logic [4:0] func5);
    return func5 inside {FCVT_S_W, FMV_W_X};
  endfunction

endpackage

// File: rtl/fpu_sb_slot.sv
// One scoreboard entry: remembers an in-flight FP op and counts down its remaining latency.
// The entry is free again on the edge after its count reaches 1 (its write-back cycle).
module fpu_sb_slot
  import fpu_issue_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [REG_AW-1:0] load_rd,
  input  logic              load_to_int,
  input  fp_class_e         load_cls,
  input  logic [CNT_W-1:0]  load_cnt,
  output logic              valid,
  output logic [REG_AW-1:0] rd,
  output logic              to_int,
  output fp_class_e         cls,
  output logic [CNT_W-1:0]  cnt
);

  // NOTE: every register here is written with <= so all slots update from the same pre-edge
  // snapshot; a blocking write would let later logic in the same edge see the new value.
  always_ff @(posedge clk) begin
    // NOTE: every field is reset, not only valid, so the count compares never see stale values.
    if (rst || clear) begin
      valid  <= 1'b0;
      rd     <= '0;
      to_int <= 1'b0;
      cls    <= CLS_ADD;
      cnt    <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      rd     <= load_rd;
      to_int <= load_to_int;
      cls    <= load_cls;
      cnt    <= load_cnt;
    end else if (valid) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Multi-cycle FP issue controller: classifies OP-FP instructions, tracks them in a
// latency-counting scoreboard, stalls on hazards and drives the single FP write-back port.
module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int MAX_OUTST = 4,
  parameter int LAT_ADD   = 3,
  parameter int LAT_MUL   = 4,
  parameter int LAT_DIV   = 12,
  parameter int LAT_MISC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [6:0]        op,
  input  logic [4:0]        func5,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              flush,
  output logic              stall,
  output logic              fpu_issue,
  output logic [1:0]        issue_class,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_to_int,
  output logic              wb_to_fp
);

  localparam int LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int LAT_DM  = (LAT_DIV > LAT_MISC) ? LAT_DIV : LAT_MISC;
  localparam int LAT_MAX = (LAT_AM > LAT_DM) ? LAT_AM : LAT_DM;
  // Wide enough to hold LAT_MAX+1 for the write-back collision compare.
  localparam int CNT_W   = $clog2(LAT_MAX + 2);

  logic                 is_fp, new_to_int, chk_rs1;
  logic                 hazard, any_free, wb_hit, wb_hit_int;
  fp_class_e            new_cls;
  logic [CNT_W-1:0]     new_lat, new_lat_p1;
  logic [REG_AW-1:0]    wb_hit_rd;
  logic [MAX_OUTST-1:0] alloc_oh, slot_load, slot_valid, slot_to_int;
  logic [REG_AW-1:0]    slot_rd  [MAX_OUTST];
  fp_class_e            slot_cls [MAX_OUTST];
  logic [CNT_W-1:0]     slot_cnt [MAX_OUTST];

  assign is_fp      = id_valid && (op == OP_FP);
  assign new_cls    = class_of(func5);
  assign new_lat    = CNT_W'(lat_of(new_cls, LAT_ADD, LAT_MUL, LAT_DIV, LAT_MISC));
  assign new_lat_p1 = new_lat + CNT_W'(1);
  assign new_to_int = dest_is_int(func5);
  assign chk_rs1    = !rs1_is_int(func5);

  // A slot at cnt==1 writes back this cycle (write-first regfile), so it neither blocks nor is busy.
  always_comb begin
    // NOTE: defaults come first so no path through the loop can infer a latch.
    hazard     = 1'b0;
    any_free   = 1'b0;
    alloc_oh   = '0;
    wb_hit     = 1'b0;
    wb_hit_rd  = '0;
    wb_hit_int = 1'b0;
    for (int i = 0; i < MAX_OUTST; i++) begin
      if (slot_valid[i] && slot_cnt[i] > CNT_W'(1)) begin
        if (!slot_to_int[i] && ((chk_rs1 && rs1 == slot_rd[i]) || rs2 == slot_rd[i]))
          hazard = 1'b1;
        if (slot_to_int[i] == new_to_int && rd == slot_rd[i]) hazard = 1'b1;
        if (slot_cls[i] == CLS_DIV && new_cls == CLS_DIV) hazard = 1'b1;
      end else if (!any_free) begin
        any_free    = 1'b1;
        alloc_oh[i] = 1'b1;
      end
      if (slot_valid[i] && slot_cnt[i] == new_lat_p1) hazard = 1'b1;
      if (slot_valid[i] && slot_cnt[i] == CNT_W'(1) && !wb_hit) begin
        wb_hit     = 1'b1;
        wb_hit_rd  = slot_rd[i];
        wb_hit_int = slot_to_int[i];
      end
    end
  end

  assign stall       = !rst && is_fp && (hazard || !any_free);
  assign fpu_issue   = !rst && is_fp && !stall && !flush;
  assign issue_class = fpu_issue ? new_cls : CLS_ADD;
  assign slot_load   = fpu_issue ? alloc_oh : '0;

  assign wb_valid  = !rst && !flush && wb_hit;
  assign wb_rd     = wb_valid ? wb_hit_rd : '0;
  assign wb_to_int = wb_valid && wb_hit_int;
  assign wb_to_fp  = wb_valid && !wb_hit_int;

  for (genvar g = 0; g < MAX_OUTST; g++) begin : g_slot
    fpu_sb_slot #(
      .REG_AW(REG_AW),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .clear      (flush),
      .load       (slot_load[g]),
      .load_rd    (rd),
      .load_to_int(new_to_int),
      .load_cls   (new_cls),
      .load_cnt   (new_lat),
      .valid      (slot_valid[g]),
      .rd         (slot_rd[g]),
      .to_int     (slot_to_int[g]),
      .cls        (slot_cls[g]),
      .cnt        (slot_cnt[g])
    );
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios plus random traffic, all checked every cycle
// against a model that tracks in-flight ops by their absolute write-back cycle.
module tb_fpu_issue_ctrl;

  localparam int REG_AW    = 5;
  localparam int MAX_OUTST = 4;
  localparam int LAT_ADD   = 3;
  localparam int LAT_MUL   = 4;
  localparam int LAT_DIV   = 12;
  localparam int LAT_MISC  = 1;
  localparam logic [6:0] OPFP = 7'b1010011;

  logic              clk = 1'b0;
  logic              rst, id_valid, flush;
  logic [6:0]        op;
  logic [4:0]        func5;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic              stall, fpu_issue, wb_valid, wb_to_int, wb_to_fp;
  logic [1:0]        issue_class;
  logic [REG_AW-1:0] wb_rd;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .REG_AW(REG_AW), .MAX_OUTST(MAX_OUTST), .LAT_ADD(LAT_ADD),
    .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV), .LAT_MISC(LAT_MISC)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .op(op), .func5(func5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .flush(flush), .stall(stall),
    .fpu_issue(fpu_issue), .issue_class(issue_class), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_to_int(wb_to_int), .wb_to_fp(wb_to_fp)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, got, want);
  endtask

  // Reference model: each in-flight op is just "writes rd to file X at absolute cycle N".
  typedef struct {
    longint wb_cyc;
    int     rd;
    bit     to_int;
    bit     is_div;
  } flight_t;

  flight_t fl_q[$];
  longint  now = 0;

  function automatic logic [1:0] cls_for(input logic [4:0] f);
    case (f)
      5'b00000, 5'b00001: return 2'b00;
      5'b00010:           return 2'b01;
      5'b00011, 5'b01011: return 2'b10;
      default:            return 2'b11;
    endcase
  endfunction

  function automatic int lat_for(input logic [4:0] f);
    case (cls_for(f))
      2'b00:   return LAT_ADD;
      2'b01:   return LAT_MUL;
      2'b10:   return LAT_DIV;
      default: return LAT_MISC;
    endcase
  endfunction

  // Per-scenario observation log, indexed by destination register.
  int t_rel;
  int issue_at [32];
  int wb_at    [32];
  bit wb_int   [32];

  task automatic start_scn();
    t_rel = 0;
    for (int i = 0; i < 32; i++) begin
      issue_at[i] = -1;
      wb_at[i]    = -1;
      wb_int[i]   = 1'b0;
    end
  endtask

  task automatic run_cycle(input bit v, input logic [6:0] o, input logic [4:0] f,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input bit fl, input bit r);
    bit is_fp, dint, chk1, is_div, hz, exp_stall, exp_issue, exp_wbv, exp_wint;
    int lat, nblock, exp_wrd;
    id_valid = v; op = o; func5 = f; rd = d; rs1 = s1; rs2 = s2; flush = fl; rst = r;
    @(negedge clk);
    is_fp  = v && (o == OPFP);
    lat    = lat_for(f);
    is_div = (cls_for(f) == 2'b10);
    dint   = f inside {5'b11100, 5'b11000, 5'b10100};
    chk1   = !(f inside {5'b11010, 5'b11110});
    hz = 0; nblock = 0; exp_wbv = 0; exp_wrd = 0; exp_wint = 0;
    foreach (fl_q[i]) begin
      if (fl_q[i].wb_cyc == now) begin
        exp_wbv  = 1;
        exp_wrd  = fl_q[i].rd;
        exp_wint = fl_q[i].to_int;
      end else begin
        nblock++;
        if (!fl_q[i].to_int && ((chk1 && int'(s1) == fl_q[i].rd) || int'(s2) == fl_q[i].rd)) hz = 1;
        if (fl_q[i].to_int == dint && int'(d) == fl_q[i].rd) hz = 1;
        if (fl_q[i].is_div && is_div) hz = 1;
      end
      if (fl_q[i].wb_cyc == now + lat) hz = 1;
    end
    if (nblock >= MAX_OUTST) hz = 1;
    exp_stall = !r && is_fp && hz;
    exp_issue = !r && is_fp && !hz && !fl;
    if (r || fl) exp_wbv = 0;

    check("stall", stall, exp_stall);
    check("fpu_issue", fpu_issue, exp_issue);
    if (exp_issue) check("issue_class", issue_class, cls_for(f));
    check("wb_valid", wb_valid, exp_wbv);
    if (exp_wbv || r) check("wb_rd", wb_rd, exp_wbv ? exp_wrd : 0);
    check("wb_to_int", wb_to_int, exp_wbv && exp_wint);
    check("wb_to_fp", wb_to_fp, exp_wbv && !exp_wint);

    if (fpu_issue === 1'b1) issue_at[d] = t_rel;
    if (wb_valid === 1'b1) begin
      wb_at[wb_rd]  = t_rel;
      wb_int[wb_rd] = wb_to_int;
    end

    @(posedge clk);
    if (r || fl) fl_q.delete();
    else begin
      for (int i = fl_q.size() - 1; i >= 0; i--)
        if (fl_q[i].wb_cyc <= now) fl_q.delete(i);
      if (exp_issue)
        fl_q.push_back('{wb_cyc: now + lat, rd: int'(d), to_int: dint, is_div: is_div});
    end
    now++;
    t_rel++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) run_cycle(1'b0, OPFP, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic fp(input logic [4:0] f, input logic [4:0] d, input logic [4:0] s1,
                    input logic [4:0] s2);
    run_cycle(1'b1, OPFP, f, d, s1, s2, 1'b0, 1'b0);
  endtask

  // Front end holds the instruction until it issues (bounded).
  task automatic hold(input logic [4:0] f, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2);
    int k = 0;
    do begin
      fp(f, d, s1, s2);
      k++;
    end while (issue_at[d] < 0 && k < 40);
  endtask

  logic [4:0] f5_tab [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011, 5'b11000,
                              5'b11010, 5'b11100, 5'b11110, 5'b10100, 5'b00100, 5'b00101};

  initial begin
    id_valid = 0; op = '0; func5 = '0; rd = '0; rs1 = '0; rs2 = '0; flush = 0; rst = 1;
    @(posedge clk);
    #1;

    // Reset held two cycles with a valid FADD presented.
    start_scn();
    run_cycle(1'b1, OPFP, 5'b00000, 5'd5, 5'd1, 5'd2, 1'b0, 1'b1);
    run_cycle(1'b1, OPFP, 5'b00000, 5'd5, 5'd1, 5'd2, 1'b0, 1'b1);
    idle(2);
    check("rst_no_issue", issue_at[5], -1);

    // Single FADD latency.
    start_scn();
    fp(5'b00000, 5'd5, 5'd1, 5'd2);
    idle(5);
    check("fadd_issue_cyc", issue_at[5], 0);
    check("fadd_wb_cyc", wb_at[5], 3);
    check("fadd_wb_int", wb_int[5], 0);

    // RAW on rs1 behind FMUL.
    idle(30); start_scn();
    fp(5'b00010, 5'd7, 5'd0, 5'd0);
    hold(5'b00000, 5'd8, 5'd7, 5'd0);
    idle(6);
    check("raw_issue_cyc", issue_at[8], 4);
    check("raw_mul_wb", wb_at[7], 4);
    check("raw_add_wb", wb_at[8], 7);

    // Write-back port collision.
    idle(30); start_scn();
    fp(5'b00010, 5'd1, 5'd0, 5'd0);
    hold(5'b00000, 5'd2, 5'd0, 5'd0);
    idle(6);
    check("coll_issue_cyc", issue_at[2], 2);
    check("coll_mul_wb", wb_at[1], 4);
    check("coll_add_wb", wb_at[2], 5);

    // Unpipelined divider: FSQRT waits for FDIV.
    idle(30); start_scn();
    fp(5'b00011, 5'd3, 5'd0, 5'd0);
    hold(5'b01011, 5'd4, 5'd0, 5'd0);
    idle(14);
    check("div_issue_cyc", issue_at[4], 12);
    check("div_wb", wb_at[3], 12);
    check("sqrt_wb", wb_at[4], 24);

    // Integer-destination write-back.
    idle(30); start_scn();
    fp(5'b11000, 5'd9, 5'd0, 5'd0);
    idle(3);
    check("cvt_wb_cyc", wb_at[9], 1);
    check("cvt_to_int", wb_int[9], 1);

    // Flush kills the divide; the next op issues at once.
    idle(30); start_scn();
    fp(5'b00011, 5'd10, 5'd0, 5'd0);
    idle(4);
    run_cycle(1'b0, OPFP, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    fp(5'b00000, 5'd11, 5'd0, 5'd0);
    idle(10);
    check("flush_div_wb", wb_at[10], -1);
    check("flush_add_issue", issue_at[11], 6);
    check("flush_add_wb", wb_at[11], 9);

    // All slots busy: fifth op waits for the first free slot.
    idle(30); start_scn();
    fp(5'b00011, 5'd12, 5'd0, 5'd0);
    fp(5'b00010, 5'd13, 5'd0, 5'd0);
    fp(5'b00010, 5'd14, 5'd0, 5'd0);
    fp(5'b00010, 5'd15, 5'd0, 5'd0);
    hold(5'b00010, 5'd16, 5'd0, 5'd0);
    idle(14);
    check("full_4th_issue", issue_at[15], 3);
    check("full_5th_issue", issue_at[16], 5);

    // Random traffic against the model.
    idle(30);
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] f;
      logic [6:0] o;
      f = ($urandom_range(0, 7) == 0) ? 5'($urandom) : f5_tab[$urandom_range(0, 11)];
      o = ($urandom_range(0, 7) == 0) ? 7'($urandom) : OPFP;
      run_cycle($urandom_range(0, 4) != 0, o, f,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
    end
    idle(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
